inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage feeding the single-cycle cpu core's `Inst` input.
- Holds the program counter and a synchronous-read instruction memory.
- Presents one 32-bit MIPS instruction per clock, tagged with its PC and a valid bit.
- Accepts stall and branch/jump redirect from the core; has a program-load port for bench and boot.

Parameters:
- IMEM_AW, 8, log2 of instruction memory depth in 32-bit words (256 words).
- RESET_PC, 32'h0000_0000, first fetch address after reset or after program load.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold the current `Inst`/`pc_out` and do not advance.
- redirect  in  1  taken branch/jump; restart fetch at `redirect_pc`.
- redirect_pc  in  32  target byte address.
- load_we  in  1  program-load write strobe; suspends fetch while high.
- load_addr  in  IMEM_AW  word address for the load write.
- load_data  in  32  instruction word to write.
- Inst  out  32  instruction to the core.
- pc_out  out  32  byte address of `Inst`.
- pc_plus4  out  32  pc_out + 4, for link/branch arithmetic.
- inst_valid  out  1  `Inst` is a real fetched instruction (not a bubble).
- misalign_err  out  1  sticky flag: a redirect target had bits[1:0] != 0.

Behaviour:
- Reset (async, rst_n=0):
  - Inst=32'h0000_0000 (NOP: sll $0,$0,0), pc_out=RESET_PC, inst_valid=0, misalign_err=0.
  - fetch_pc=RESET_PC, state=RUN.
  - Memory contents are not reset.
- Internal state:
  - fetch_pc: next address to read.
  - State enum: RUN, LOAD.
- Memory:
  - Word index = addr[IMEM_AW+1:2]; higher bits are ignored (aliasing, no fault).
  - Read is synchronous. The `Inst` register is the read register, so latency is 1 cycle from fetch_pc to `Inst`.
  - Write port is used only by load.
- RUN, per rising edge, priority high to low:
  1. load_we=1: write mem[load_addr]=load_data; Inst<=NOP, inst_valid<=0; state<=LOAD.
  2. redirect=1 (overrides stall):
     - fetch_pc<={redirect_pc[31:2],2'b00}.
     - Inst<=NOP, inst_valid<=0: exactly one bubble.
     - pc_out holds its previous value.
     - If redirect_pc[1:0]!=0, misalign_err<=1.
  3. stall=1: all registers hold.
  4. Otherwise: Inst<=mem[fetch_pc], pc_out<=fetch_pc, inst_valid<=1, fetch_pc<=fetch_pc+4.
- fetch_pc arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- pc_plus4 is combinational pc_out+4, also modulo 2^32.
- LOAD:
  - Each cycle with load_we=1 writes the memory; redirect and stall are ignored.
  - Outputs hold NOP/invalid.
  - First cycle with load_we=0: fetch_pc<=RESET_PC, state<=RUN, still invalid. The first valid instruction appears on the following edge.
- Reset mid-operation (any state) returns immediately to the reset values above. Loaded memory is retained.
- misalign_err is cleared only by reset.

Decomposition:
- Shared package `cpu_pkg`:
  - NOP_INST = 32'h0000_0000.
  - Default RESET_PC.
  - Fetch state enum {RUN, LOAD}.
  - Instruction width constant 32.
- One natural sub-module: `imem_sync`.
  - Parameterised by IMEM_AW.
  - Single read port (registered data with enable for stall) and single write port.
  - Inferable as block RAM.

Test Plan:
- Reset release:
  - Preload mem[0]=32'h0000_0820 (add $1,$0,$0), mem[1]=32'h2001_0001 (addi $1,$0,1).
  - Release rst_n.
  - Required: cycle 1 Inst=0000_0820, pc_out=0, inst_valid=1; cycle 2 Inst=2001_0001, pc_out=4, pc_plus4=8.
- Stall:
  - Assert stall for 3 cycles while Inst=2001_0001.
  - Required: Inst, pc_out=4 and inst_valid=1 held for all 3 cycles; next cycle pc_out=8.
- Redirect:
  - redirect=1 with redirect_pc=32'h20, with stall=1 simultaneously.
  - Required: next cycle Inst=0, inst_valid=0; following cycle pc_out=32'h20, Inst=mem[8].
- Misaligned redirect:
  - redirect_pc=32'h22.
  - Required: misalign_err=1 (sticky); fetch resumes at 32'h20.
- Program load mid-run:
  - Pulse load_we for 2 cycles writing mem[0]=32'h0021_0820 (add $1,$1,$1) and mem[1].
  - Required: inst_valid=0 during load and the cycle after; then pc_out=0, Inst=0021_0820.
- Async reset mid-fetch:
  - Drop rst_n between edges.
  - Required: outputs go to reset values without a clock edge; the memory still holds the loaded program on restart.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu front end.
// Fetch stage and its instruction memory import this package.
package cpu_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/imem_sync.sv
// Instruction memory: one write port, one synchronous read port.
// The read register doubles as the fetch stage's instruction register.
module imem_sync
    import cpu_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [IMEM_AW-1:0] wr_addr,
    input  logic [INST_W-1:0]  wr_data,
    input  logic               rd_en,
    input  logic               rd_clr,
    input  logic [IMEM_AW-1:0] rd_addr,
    output logic [INST_W-1:0]  rd_data
);

    logic [INST_W-1:0] mem [0:(1<<IMEM_AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_clr injects a NOP bubble; a low rd_en holds the last word (stall).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= NOP_INST;
        end else if (rd_clr) begin
            rd_data <= NOP_INST;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC sequencing, stall/redirect handling and
// a program-load port that suspends fetch while it writes the memory.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int          IMEM_AW  = 8,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               load_we,
    input  logic [IMEM_AW-1:0] load_addr,
    input  logic [31:0]        load_data,
    output logic [31:0]        Inst,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_plus4,
    output logic               inst_valid,
    output logic               misalign_err
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  fetch_pc_reg, fetch_pc_next;
    logic [31:0]  pc_out_reg, pc_out_next;
    logic         valid_reg, valid_next;
    logic         misalign_reg, misalign_next;
    logic         rd_en;
    logic         rd_clr;

    imem_sync #(
        .IMEM_AW (IMEM_AW)
    ) u_imem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (load_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr),
        .rd_addr (fetch_pc_reg[IMEM_AW+1:2]),
        .rd_data (Inst)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            fetch_pc_reg <= RESET_PC;
            pc_out_reg   <= RESET_PC;
            valid_reg    <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            pc_out_reg   <= pc_out_next;
            valid_reg    <= valid_next;
            misalign_reg <= misalign_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        pc_out_next   = pc_out_reg;
        valid_next    = valid_reg;
        misalign_next = misalign_reg;
        rd_en         = 1'b0;
        rd_clr        = 1'b0;
        case (state_reg)
            RUN: begin
                if (load_we) begin
                    state_next = LOAD;
                    valid_next = 1'b0;
                    rd_clr     = 1'b1;
                end else if (redirect) begin
                    // Redirect beats stall; pc_out keeps the old value for the bubble.
                    fetch_pc_next = {redirect_pc[31:2], 2'b00};
                    valid_next    = 1'b0;
                    rd_clr        = 1'b1;
                    if (redirect_pc[1:0] != 2'b00) begin
                        misalign_next = 1'b1;
                    end
                end else if (!stall) begin
                    rd_en         = 1'b1;
                    pc_out_next   = fetch_pc_reg;
                    valid_next    = 1'b1;
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                end
            end
            LOAD: begin
                valid_next = 1'b0;
                rd_clr     = 1'b1;
                if (!load_we) begin
                    fetch_pc_next = RESET_PC;
                    state_next    = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign pc_out       = pc_out_reg;
    assign pc_plus4     = pc_out_reg + 32'd4;
    assign inst_valid   = valid_reg;
    assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised and directed bench for inst_fetch against a behavioural
// model of the fetch rules (memory image, PC, bubble and load tracking).
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        load_we;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_mem [0:255];
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    logic        m_valid;
    logic        m_err;
    logic        m_loading;
    int          cyc = 0;

    inst_fetch #(
        .IMEM_AW  (8),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .Inst         (inst),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .inst_valid   (inst_valid),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_inst    = 32'h0;
        m_pc      = 32'h0;
        m_fetch   = 32'h0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
        m_loading = 1'b0;
    endtask

    task automatic model_step(input logic ld, input logic [7:0] la, input logic [31:0] ldd,
                              input logic st, input logic rd, input logic [31:0] rp);
        if (ld) m_mem[la] = ldd;
        if (m_loading) begin
            if (!ld) begin
                m_loading = 1'b0;
                m_fetch   = 32'h0;
            end
        end else if (ld) begin
            m_loading = 1'b1;
            m_inst    = 32'h0;
            m_valid   = 1'b0;
        end else if (rd) begin
            m_fetch = rp & 32'hFFFF_FFFC;
            m_inst  = 32'h0;
            m_valid = 1'b0;
            if (rp % 4 != 0) m_err = 1'b1;
        end else if (!st) begin
            m_inst  = m_mem[(m_fetch / 4) % 256];
            m_pc    = m_fetch;
            m_valid = 1'b1;
            m_fetch = m_fetch + 32'd4;
        end
    endtask

    task automatic compare_all();
        check("inst", inst, m_inst);
        check("pc_out", pc_out, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("valid", {31'b0, inst_valid}, {31'b0, m_valid});
        check("misalign", {31'b0, misalign_err}, {31'b0, m_err});
    endtask

    // One transaction: drive after negedge, clock, model, sample #1 after posedge.
    task automatic cycle(input logic ld, input logic [7:0] la, input logic [31:0] ldd,
                         input logic st, input logic rd, input logic [31:0] rp);
        load_we = ld; load_addr = la; load_data = ldd;
        stall = st; redirect = rd; redirect_pc = rp;
        @(posedge clk);
        model_step(ld, la, ldd, st, rd, rp);
        #1;
        cyc++;
        $display("cyc %0d ld=%0b st=%0b rd=%0b rp=%08h -> inst=%08h pc=%08h v=%0b err=%0b",
                 cyc, ld, st, rd, rp, inst, pc_out, inst_valid, misalign_err);
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Drop rst_n between edges and confirm outputs clear without a clock.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_inst"}, inst, 32'h0);
        check({tag, "_pc"}, pc_out, 32'h0);
        check({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
        check({tag, "_err"}, {31'b0, misalign_err}, 32'h0);
        $display("async reset %s", tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] rp;
        logic        ld, st, rd;
        int          ld_left;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        load_we = 1'b0; load_addr = 8'h0; load_data = 32'h0;
        model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        @(negedge clk);
        #1;
        check("reset_inst", inst, 32'h0);
        check("reset_valid", {31'b0, inst_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the whole memory so every fetch address is defined.
        for (int i = 0; i < 256; i++) begin
            w = $urandom();
            if (i == 0) w = 32'h0000_0820;
            if (i == 1) w = 32'h2001_0001;
            if (i == 8) w = 32'h1234_5678;
            cycle(1'b1, i[7:0], w, 1'b0, 1'b0, 32'h0);
        end
        async_reset("rst_load");

        // Reset release: first two fetches
        cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("c1_inst", inst, 32'h0000_0820);
        check("c1_pc", pc_out, 32'h0);
        check("c1_valid", {31'b0, inst_valid}, 32'h1);
        cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("c2_inst", inst, 32'h2001_0001);
        check("c2_plus4", pc_plus4, 32'h8);

        // Stall holds for three cycles
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 32'h0);
            check("stall_inst", inst, 32'h2001_0001);
            check("stall_pc", pc_out, 32'h4);
        end
        cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("post_stall_pc", pc_out, 32'h8);

        // Redirect together with stall
        cycle(1'b0, 8'h0, 32'h0, 1'b1, 1'b1, 32'h20);
        check("redir_bubble_v", {31'b0, inst_valid}, 32'h0);
        check("redir_bubble_pc", pc_out, 32'h8);
        cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("redir_pc", pc_out, 32'h20);
        check("redir_inst", inst, 32'h1234_5678);

        // Misaligned redirect
        cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b1, 32'h22);
        check("mis_err", {31'b0, misalign_err}, 32'h1);
        cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("mis_pc", pc_out, 32'h20);
        idle(2);
        check("mis_sticky", {31'b0, misalign_err}, 32'h1);

        // Program load mid-run
        cycle(1'b1, 8'h0, 32'h0021_0820, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 8'h1, 32'h2002_0002, 1'b0, 1'b1, 32'h40);
        cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("load_after_v", {31'b0, inst_valid}, 32'h0);
        cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("load_pc", pc_out, 32'h0);
        check("load_inst", inst, 32'h0021_0820);

        // Async reset mid-fetch; memory must survive
        idle(3);
        async_reset("rst_mid");
        cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("retain_inst", inst, 32'h0021_0820);

        // PC wrap and aliasing
        cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        cycle(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("wrap_next", pc_out, 32'h0);

        // Random traffic
        async_reset("rst_rand");
        ld_left = 0;
        for (int i = 0; i < 400; i++) begin
            if (ld_left == 0 && $urandom_range(0, 29) == 0) ld_left = $urandom_range(1, 4);
            ld = (ld_left != 0);
            if (ld_left != 0) ld_left--;
            st = ($urandom_range(0, 4) == 0);
            rd = ($urandom_range(0, 7) == 0);
            rp = $urandom();
            if ($urandom_range(0, 9) != 0) rp[1:0] = 2'b00;
            cycle(ld, 8'($urandom()), $urandom(), st, rd, rp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
